// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and helpers for the scoreboarded register file:
//               FSM state encoding and the address-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  // Two-state controller: post-reset clear sweep, then normal operation.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Address width for a register count; never narrower than one bit.
  function automatic int calc_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : One pending bit per register. An issue sets the bit for its
//               destination, a writeback clears it; when both target the same
//               register in one cycle the set wins. Bit 0 is never pending.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en_i,
  input  logic [AW-1:0]    set_addr_i,
  input  logic             clr_en_i,
  input  logic [AW-1:0]    clr_addr_i,
  output logic [NREGS-1:0] pending_o
);

  logic [NREGS-1:0] pending_q;
  logic [NREGS-1:0] pending_d;

  // Next pending vector: clear first so a same-address set overrides it.
  always_comb begin
    pending_d = pending_q;
    if (clr_en_i) begin
      pending_d[clr_addr_i] = 1'b0;
    end
    if (set_en_i) begin
      pending_d[set_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending bits register; reset leaves nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Multi-read-port register file with a single writeback port,
//               per-register pending scoreboard, optional write-through and a
//               post-reset zeroing sweep (register contents have no reset).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = calc_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [XLEN-1:0]   wr_data,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic              init_done
);

  state_e          state_q;
  state_e          state_d;
  logic [AW-1:0]   ptr_q;
  logic [AW-1:0]   ptr_d;
  logic            init_done_q;
  logic [XLEN-1:0] mem_q [NREGS];

  logic             w_ready;
  logic             w_wr;
  logic             w_iss;
  logic [NREGS-1:0] w_pending;

  // Writes and issues only take effect once the sweep is over; x0 is inert.
  assign w_ready = (state_q == ST_READY);
  assign w_wr    = w_ready && wr_en  && (wr_addr  != '0);
  assign w_iss   = w_ready && iss_en && (iss_addr != '0);

  // Controller next state: walk the pointer up to NREGS-1, then go READY.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(NREGS - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Controller registers; reset restarts the sweep at register 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      ptr_q       <= AW'(1);
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      init_done_q <= (state_d == ST_READY);
    end
  end

  assign init_done = init_done_q;

  // Register storage: zeroed by the sweep, otherwise loaded by writeback.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[ptr_q] <= '0;
    end else if (w_wr) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (w_iss),
    .set_addr_i (iss_addr),
    .clr_en_i   (w_wr),
    .clr_addr_i (wr_addr),
    .pending_o  (w_pending)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit_wr;
    logic          hit_iss;

    assign ra      = rd_addr[k*AW +: AW];
    // Write-through hit; w_wr already excludes x0.
    assign hit_wr  = (BYPASS != 0) && w_wr && (wr_addr == ra);
    assign hit_iss = w_iss && (iss_addr == ra);

    assign rd_data[k*XLEN +: XLEN] = (!w_ready || (ra == '0)) ? '0 :
                                     hit_wr                   ? wr_data :
                                                                mem_q[ra];
    // A forwarded write retires the producer unless a new one issues now.
    assign rd_busy[k] = w_ready && w_pending[ra] && !(hit_wr && !hit_iss);
  end

endmodule : regfile_sb
`default_nettype wire
